// File: rtl/halt_result_checker_pkg.sv
// Shared types for the halt/result self-check block: FSM state encoding and
// first-failure cause codes reported on fail_code.
package checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_CHK_PC = 3'd2,
    ST_RD     = 3'd3,
    ST_CMP    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_PC      = 2'b01;
  localparam logic [1:0] FAIL_MEM     = 2'b10;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b11;

endpackage

// File: rtl/halt_result_checker.sv
// Waits for CPU HALT under a cycle timeout, then checks the halted PC and a
// list of masked data-memory words, reporting pass/done and the first failure.
//
// state   | meaning
// IDLE    | disarmed, all outputs 0
// RUN     | waiting for halt, timeout counter running
// CHK_PC  | compare halted pc against exp_pc
// RD      | present chk_addr[i] to RAM
// CMP     | compare returned word i under mask
// DONE    | results held until next start
module halt_result_checker
  import checker_pkg::*;
#(
  parameter int                   DATA_W         = 16,
  parameter int                   ADDR_W         = 8,
  parameter int                   PC_W           = 9,
  parameter int                   N_CHECKS       = 4,
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               halt,
  input  logic [PC_W-1:0]                    pc,
  input  logic [PC_W-1:0]                    exp_pc,
  input  logic [N_CHECKS*ADDR_W-1:0]         chk_addr,
  input  logic [N_CHECKS*DATA_W-1:0]         chk_data,
  input  logic [N_CHECKS*DATA_W-1:0]         chk_mask,
  output logic                               mem_req,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [DATA_W-1:0]                  mem_rdata,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [1:0]                         fail_code,
  output logic [$clog2(N_CHECKS+1)-1:0]      fail_idx,
  output logic [$clog2(N_CHECKS+2)-1:0]      err_count
);

  localparam int IDX_W = $clog2(N_CHECKS + 1);
  localparam int ERR_W = $clog2(N_CHECKS + 2);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_CHECKS - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_CYCLES - 1'b1;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [1:0]           code_q, code_d;
  logic [IDX_W-1:0]     fidx_q, fidx_d;
  logic [ERR_W-1:0]     err_q, err_d;

  logic [IDX_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] msk_word;
  logic              word_bad;

  // Wraps to 0 on the last entry so the address lookup below never leaves range.
  assign idx_nxt  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign exp_word = chk_data[int'(idx_q)*DATA_W +: DATA_W];
  assign msk_word = chk_mask[int'(idx_q)*DATA_W +: DATA_W];
  assign word_bad = |((mem_rdata ^ exp_word) & msk_word);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    done_d  = done_q;
    pass_d  = pass_q;
    code_d  = code_q;
    fidx_d  = fidx_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          err_d   = '0;
          code_d  = FAIL_NONE;
          fidx_d  = '0;
          pass_d  = 1'b0;
          done_d  = 1'b0;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (halt) begin
          state_d = ST_CHK_PC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          code_d  = FAIL_TIMEOUT;
          err_d   = ERR_W'(1);
        end
      end

      ST_CHK_PC: begin
        if (pc != exp_pc) begin
          err_d  = err_q + 1'b1;
          code_d = FAIL_PC;
        end
        state_d = ST_RD;
        idx_d   = '0;
        addr_d  = chk_addr[0 +: ADDR_W];
      end

      ST_RD: begin
        state_d = ST_CMP;
      end

      ST_CMP: begin
        if (word_bad) begin
          err_d = err_q + 1'b1;
          if (code_q == FAIL_NONE) begin
            code_d = FAIL_MEM;
            fidx_d = idx_q;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_RD;
          idx_d   = idx_nxt;
          addr_d  = chk_addr[int'(idx_nxt)*ADDR_W +: ADDR_W];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      code_q  <= FAIL_NONE;
      fidx_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
      fidx_q  <= fidx_d;
      err_q   <= err_d;
    end
  end

  // Read-port ownership is decoded from the state register alone so the RAM
  // address mux at the top level sees no input-to-output paths.
  assign mem_req   = (state_q == ST_RD) || (state_q == ST_CMP);
  assign mem_addr  = mem_req ? addr_q : '0;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = code_q;
  assign fail_idx  = fidx_q;
  assign err_count = err_q;

endmodule
